// File: rtl/data_capture_buffer_pkg.sv
// rtl/data_capture_buffer_pkg.sv - shared encodings for the data capture buffer
// Register offsets, capture modes, status-word layout and FSM states.
package data_capture_buffer_pkg;

  localparam logic [3:0] OFF_CTRL    = 4'd0;
  localparam logic [3:0] OFF_SAMPLES = 4'd1;
  localparam logic [3:0] OFF_NUM     = 4'd2;
  localparam logic [3:0] OFF_SPEC    = 4'd3;

  typedef enum logic [1:0] {
    MODE_SAMPLE = 2'd0,
    MODE_CONT   = 2'd1,
    MODE_TRIG   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_TS    = 3'd2,
    S_SEL   = 3'd3,
    S_WR    = 3'd4
  } state_t;

  localparam int STAT_BUSY     = 31;
  localparam int STAT_MODE_LSB = 29;
  localparam int STAT_TRIG     = 28;
  localparam int STAT_WRAP     = 27;
  localparam int STAT_NUM_LSB  = 23;

  localparam logic [11:0] RADDR_STATUS = 12'h800;
  localparam logic [11:0] RADDR_TRIG   = 12'h801;
  localparam logic [11:0] RADDR_FCNT   = 12'h802;

  // Bit 31 tags the word as a frame header; the stamp saturates instead of aliasing into it.
  function automatic logic [31:0] ts_word(input logic [31:0] t);
    return {1'b1, (t[31] ? 31'h7FFF_FFFF : t[30:0])};
  endfunction

endpackage

// File: rtl/data_capture_buffer_ram.sv
// rtl/data_capture_buffer_ram.sv - simple dual-port capture RAM
// Write port A, registered read port B, single clock; contents are not reset.
module data_buf_ram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_capture_buffer.sv
// rtl/data_capture_buffer.sv - framed multi-signal capture into a circular RAM
// Each strobe captures a timestamp word followed by num selected signal samples.
module data_capture_buffer
  import data_capture_buffer_pkg::*;
#(
  parameter int         DW     = 32,
  parameter int         AW     = 10,
  parameter int         NSIG_W = 4,
  parameter logic [3:0] BASE   = 4'h7
) (
  input  logic              clkbuffer,
  input  logic              reset,
  input  logic [31:0]       ts,
  input  logic              sample_strobe,
  input  logic              trig_in,
  output logic [NSIG_W-1:0] sel_index,
  output logic [11:0]       sel_spec,
  input  logic [DW-1:0]     input_data,
  input  logic [15:0]       reg_waddr,
  input  logic [31:0]       reg_wdata,
  input  logic              reg_wen,
  input  logic [15:0]       reg_raddr,
  output logic [31:0]       reg_rdata,
  output logic              buf_busy
);

  state_t            state;
  mode_t             mode;
  logic [15:0]       samples;
  logic [NSIG_W-1:0] num;
  logic [11:0]       spec [0:(1<<NSIG_W)-1];
  logic [AW-1:0]     wptr, waddr_align;
  logic [15:0]       frame_cnt, post_cnt, trig_addr;
  logic [7:0]        missed_cnt;
  logic              wrapped, trig_seen, stop_pend;
  logic [2:0]        stb_sync, trg_sync;

  logic strobe_edge, trig_edge;
  assign strobe_edge = stb_sync[1] & ~stb_sync[2];
  assign trig_edge   = trg_sync[1] & ~trg_sync[2];

  logic  wr_hit, wr_start, wr_stop, start_ok;
  logic [3:0] wr_off;
  mode_t wr_mode;
  assign wr_hit   = reg_wen && (reg_waddr[15:12] == BASE);
  assign wr_off   = reg_waddr[11:8];
  assign wr_mode  = mode_t'(reg_wdata[3:2]);
  assign wr_stop  = wr_hit && (wr_off == OFF_CTRL) && reg_wdata[1];
  assign wr_start = wr_hit && (wr_off == OFF_CTRL) && reg_wdata[0] && !reg_wdata[1];
  assign start_ok = (wr_mode != MODE_RSVD) && !(wr_mode == MODE_SAMPLE && samples == 16'd0);

  logic [AW-1:0] wptr_inc;
  logic [15:0]   fcnt_inc, post_inc, align16, next16;
  logic          frame_done, fin_idle;
  always_comb begin
    wptr_inc = wptr + AW'(1);
    fcnt_inc = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;
    post_inc = (post_cnt == 16'hFFFF) ? post_cnt : post_cnt + 16'd1;
    align16 = '0;
    align16[AW-1:0] = waddr_align;
    next16 = '0;
    next16[AW-1:0] = wptr_inc;
    frame_done = (state == S_TS && num == '0) ||
                 (state == S_WR && sel_index == num - NSIG_W'(1));
    fin_idle = stop_pend || wr_stop ||
               (mode == MODE_SAMPLE && fcnt_inc >= samples) ||
               (mode == MODE_TRIG && trig_seen && post_inc >= samples);
  end

  assign sel_spec = spec[sel_index];

  always_ff @(posedge clkbuffer or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;  buf_busy <= 1'b0;  sel_index <= '0;
      mode <= MODE_SAMPLE;  samples <= '0;  num <= '0;
      for (int i = 0; i < (1<<NSIG_W); i++) spec[i] <= '0;
      wptr <= '0;  waddr_align <= '0;  frame_cnt <= '0;  post_cnt <= '0;
      trig_addr <= '0;  missed_cnt <= '0;  wrapped <= 1'b0;  trig_seen <= 1'b0;
      stop_pend <= 1'b0;  stb_sync <= '0;  trg_sync <= '0;
    end else begin
      stb_sync <= {stb_sync[1:0], sample_strobe};
      trg_sync <= {trg_sync[1:0], trig_in};
      if (wr_hit && state == S_IDLE) begin
        case (wr_off)
          OFF_CTRL:    mode <= wr_mode;
          OFF_SAMPLES: samples <= reg_wdata[15:0];
          OFF_NUM:     num <= reg_wdata[NSIG_W-1:0];
          OFF_SPEC:    spec[reg_waddr[NSIG_W-1:0]] <= {reg_wdata[15:12], reg_wdata[7:4], reg_wdata[3:0]};
          default: ;
        endcase
      end
      if (strobe_edge && state != S_ARMED && missed_cnt != 8'hFF)
        missed_cnt <= missed_cnt + 8'd1;
      // A trigger coinciding with frame completion points past that frame.
      if (trig_edge && state != S_IDLE && mode == MODE_TRIG && !trig_seen) begin
        trig_seen <= 1'b1;
        trig_addr <= frame_done ? next16 : align16;
      end
      if (wr_stop && (state == S_TS || state == S_SEL || state == S_WR))
        stop_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (wr_start && start_ok) begin
            state <= S_ARMED;  buf_busy <= 1'b1;
            frame_cnt <= '0;  post_cnt <= '0;  missed_cnt <= '0;
            wrapped <= 1'b0;  trig_seen <= 1'b0;  stop_pend <= 1'b0;
            wptr <= '0;  waddr_align <= '0;
          end
        end
        S_ARMED: begin
          if (wr_stop) begin
            state <= S_IDLE;  buf_busy <= 1'b0;
          end else if (strobe_edge) begin
            state <= S_TS;
          end
        end
        S_TS, S_WR: begin
          wptr <= wptr_inc;
          if (&wptr) wrapped <= 1'b1;
          if (frame_done) begin
            frame_cnt <= fcnt_inc;
            if (mode == MODE_TRIG && trig_seen) post_cnt <= post_inc;
            waddr_align <= wptr_inc;
            sel_index <= '0;
            stop_pend <= 1'b0;
            if (fin_idle) begin
              state <= S_IDLE;  buf_busy <= 1'b0;
            end else begin
              state <= S_ARMED;
            end
          end else begin
            sel_index <= (state == S_TS) ? '0 : sel_index + NSIG_W'(1);
            state <= S_SEL;
          end
        end
        S_SEL: state <= S_WR;
        default: begin
          state <= S_IDLE;  buf_busy <= 1'b0;
        end
      endcase
    end
  end

  logic          ram_we;
  logic [31:0]   wword, in32, ram_q32;
  logic [DW-1:0] ram_q;
  always_comb begin
    in32 = '0;
    in32[DW-1:0] = input_data;
    wword = (state == S_TS) ? ts_word(ts) : in32;
    ram_we = (state == S_TS) || (state == S_WR);
    ram_q32 = '0;
    ram_q32[DW-1:0] = ram_q;
  end

  data_buf_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clkbuffer),
    .we    (ram_we),
    .waddr (wptr),
    .wdata (wword[DW-1:0]),
    .raddr (reg_raddr[AW-1:0]),
    .rdata (ram_q)
  );

  logic [31:0] status;
  logic [3:0]  num4;
  always_comb begin
    num4 = '0;
    num4[NSIG_W-1:0] = num;
    status = '0;
    status[STAT_BUSY] = buf_busy;
    status[STAT_MODE_LSB +: 2] = mode;
    status[STAT_TRIG] = trig_seen;
    status[STAT_WRAP] = wrapped;
    status[STAT_NUM_LSB +: 4] = num4;
    status[15:0] = align16;
  end

  // RAM reads and register reads both land one cycle after the address.
  logic        rd_hit, rd_from_ram;
  logic [31:0] rd_reg;
  assign rd_hit = (reg_raddr[15:12] == BASE);

  always_ff @(posedge clkbuffer or posedge reset) begin
    if (reset) begin
      rd_from_ram <= 1'b0;
      rd_reg <= '0;
    end else begin
      rd_from_ram <= rd_hit && !reg_raddr[11];
      rd_reg <= '0;
      if (rd_hit && reg_raddr[11]) begin
        case (reg_raddr[11:0])
          RADDR_STATUS: rd_reg <= status;
          RADDR_TRIG:   rd_reg <= {missed_cnt, 8'h00, trig_addr};
          RADDR_FCNT:   rd_reg <= {16'h0000, frame_cnt};
          default:      rd_reg <= '0;
        endcase
      end
    end
  end

  assign reg_rdata = rd_from_ram ? ram_q32 : rd_reg;

  logic unused_bits;
  assign unused_bits = ^{reg_wdata, reg_waddr, reg_raddr, wword};

endmodule

// File: doc/data_capture_buffer.md
DATA_CAPTURE_BUFFER -- requirements
Module: data_capture_buffer

Interface
REQ-001 Parameters SHALL be: DW, default 32, sample data width (at most 32); AW, default 10, RAM address width (depth 2^AW); NSIG_W, default 4, signal-index width (at most 2^NSIG_W-1 signals per frame); BASE, default 4'h7, reg address bits [15:12] decode.
REQ-002 Ports SHALL be, in order:
- clkbuffer  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- ts  in  32  free-running timestamp.
- sample_strobe  in  1  frame-valid level, may be asynchronous.
- trig_in  in  1  capture trigger, asynchronous.
- sel_index  out  NSIG_W  signal slot being captured.
- sel_spec  out  12  {type[3:0], channel[3:0], format[3:0]} of that slot.
- input_data  in  DW  mux output; valid 1 cycle after sel_index changes.
- reg_waddr  in  16  write address.
- reg_wdata  in  32  write data.
- reg_wen  in  1  write strobe.
- reg_raddr  in  16  read address.
- reg_rdata  out  32  registered read data.
- buf_busy  out  1  capture active.

Function
REQ-003 Writes SHALL decode only when reg_wen=1 and reg_waddr[15:12]=BASE; offset = reg_waddr[11:8].
REQ-004 Offset 0 (CTRL) SHALL act as follows: wdata[0] start; wdata[1] stop; wdata[3:2] mode (0 SAMPLE, 1 CONTINUOUS, 2 TRIGGERED, 3 reserved, treated as no-op).
REQ-005 Offset 1 SHALL set samples[15:0]; offset 2 SHALL set num[NSIG_W-1:0]; offset 3 SHALL set spec[reg_waddr[NSIG_W-1:0]] = {wdata[15:12], wdata[7:4], wdata[3:0]}.
REQ-006 Writes to offsets 1-3 and mode changes SHALL be ignored while buf_busy=1; stop SHALL be honoured at any time.
REQ-007 If start and stop are set in the same write, stop SHALL win.
REQ-008 sample_strobe and trig_in SHALL each pass a 2-flop synchroniser followed by rising-edge detection; the edge pulse SHALL occur 3 cycles after the input rises.
REQ-009 States SHALL be IDLE, ARMED, TS, SEL, WR.
- IDLE->ARMED on start when mode≠3 and not (mode=SAMPLE and samples=0).
- ARMED->TS on strobe edge.
- TS writes timestamp word {1'b1, (ts[31] ? 31'h7FFFFFFF : ts[30:0])}.
- SEL drives sel_index.
- WR writes input_data zero-extended, then ->SEL if more slots remain, else ->ARMED or IDLE.
REQ-010 Each frame SHALL take 1+2*num cycles and occupy 1+num words; num=0 SHALL produce a timestamp-only frame.
REQ-011 The write pointer SHALL wrap modulo 2^AW; waddr_align SHALL update to the next free address only after the last word of a frame is written.
REQ-012 A strobe edge arriving outside ARMED SHALL be dropped and SHALL increment missed_cnt (8-bit, saturating at 255).
REQ-013 Stop mid-frame SHALL complete the current frame and then go to IDLE; frames SHALL never be truncated.
REQ-014 SAMPLE mode SHALL go to IDLE once frame_cnt=samples.
REQ-015 CONTINUOUS mode SHALL run until stop and set the wrapped flag on the first pointer wrap.
REQ-016 TRIGGERED mode SHALL run as CONTINUOUS until the first trig edge, then latch trig_addr=waddr_align and trig_seen=1, capture samples further frames, and go to IDLE.
REQ-017 A trig edge in the same cycle as frame completion SHALL latch the post-completion waddr_align.
REQ-018 Start SHALL clear frame_cnt, missed_cnt, wrapped, trig_seen and the write pointer; configuration SHALL be retained.
REQ-019 Reads with reg_raddr[15:12]=BASE SHALL return, with 1-cycle latency for all addresses:
- raddr[11]=0: RAM[raddr[AW-1:0]].
- 0x800: {busy, mode[1:0], trig_seen, wrapped, num zero-extended to 4 bits, 7'b0, waddr_align zero-extended to 16 bits}.
- 0x801: {missed_cnt, 8'b0, trig_addr[15:0]}.
- 0x802: {16'b0, frame_cnt}.
- Anything else: 0.
REQ-020 frame_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-021 Reset SHALL force state IDLE, buf_busy=0, sel_index=0, reg_rdata=0, all counters, flags, pointers, mode, samples and num to 0, and all spec entries to 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately; RAM contents are undefined afterwards.

Structure
REQ-023 A shared package SHALL hold: offset codes, mode encodings, status-word field positions, and the state encoding.
REQ-024 One sub-module data_buf_ram SHALL be instantiated: a parameterised simple dual-port RAM, DW x 2^AW, write port A, registered read port B, single clock.

Verification
REQ-025 Config num=3 and samples=4, start SAMPLE, 4 strobes -> 16 words written, waddr_align=16, frame_cnt=4, busy drops.
REQ-026 Strobe re-asserted 2 cycles after an accepted strobe, with num=3 -> missed_cnt=1 and no corrupt frame.
REQ-027 AW=4, num=3, CONTINUOUS, 5 strobes -> pointer wraps to 4, wrapped=1, waddr_align=4.
REQ-028 TRIGGERED, samples=2, trig after frame 3 -> trig_addr=12 (num=3), exactly 2 more frames, then IDLE.
REQ-029 Stop written mid-frame -> frame completes, busy=0 within 1+2*num cycles; start+stop in one write -> stays IDLE.
REQ-030 Reset mid-frame -> all outputs 0 on the next clock edge; writes to offset 2 while busy are ignored.
